// File: rtl/imem_load_ctrl.sv
// Instruction memory load controller: loads 64x32 words, then serves fetches.
// Optional checksum word on the last beat is enabled by `define IMEM_CHECKSUM_EN.
module imem_load_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_instr,
    output logic        cpu_stall,
    output logic [6:0]  ld_count,
    output logic        ld_err,
    output logic        done
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
`ifdef IMEM_CHECKSUM_EN
        S_CHECK = 3'd2,
`endif
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_count;
    logic [31:0] r_mem [64];

    logic        w_ready;
    logic        w_hs;
    logic        w_wr;
    logic        w_clr;
    logic        w_unused_addr;

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] r_sum;
    logic [31:0] r_csum;
`endif

    // Handshake qualification; ld_start in LOAD discards the word
    assign w_ready = (r_state == S_LOAD) && !r_count[6];
    assign w_hs    = w_ready && ld_valid && !ld_start;
`ifdef IMEM_CHECKSUM_EN
    assign w_wr    = w_hs && !ld_last;
    assign w_clr   = ld_start && (r_state != S_CHECK);
`else
    assign w_wr    = w_hs;
    assign w_clr   = ld_start;
`endif

    assign w_unused_addr = ^{cpu_addr[31:8], cpu_addr[1:0]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (ld_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (ld_start) begin
                    w_next = S_LOAD;
                end else if (ld_valid && !w_ready) begin
                    w_next = S_ERROR;
                end else if (w_hs && ld_last) begin
`ifdef IMEM_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_RUN;
`endif
                end
            end
`ifdef IMEM_CHECKSUM_EN
            S_CHECK: begin
                w_next = (r_sum == r_csum) ? S_RUN : S_ERROR;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Word counter, saturates at 64 because ready drops there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 7'd0;
        end else if (w_clr) begin
            r_count <= 7'd0;
        end else if (w_wr) begin
            r_count <= r_count + 7'd1;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    // Running sum of written words and capture of the checksum beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum  <= 32'd0;
            r_csum <= 32'd0;
        end else if (w_clr) begin
            r_sum  <= 32'd0;
            r_csum <= 32'd0;
        end else begin
            if (w_wr) r_sum <= r_sum + ld_data;
            if (w_hs && ld_last) r_csum <= ld_data;
        end
    end
`endif

    // Storage write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_count[5:0]] <= ld_data;
    end

    // Output decode
    always_comb begin
        ld_ready  = w_ready;
        ld_count  = r_count;
        ld_err    = (r_state == S_ERROR);
        done      = (r_state == S_RUN);
        cpu_stall = (r_state != S_RUN);
        cpu_instr = NOP;
        if (r_state == S_RUN) cpu_instr = r_mem[cpu_addr[7:2]];
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl.
// Fetch expectations are queued from a bench memory model and popped on fetch.
module tb_imem_load_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = 32'd0;
    logic        ld_last = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic [6:0]  ld_count;
    logic        ld_err;
    logic        done;

    int n_chk = 0;
    int n_pass = 0;
    int wp = 0;
    logic [31:0] m [64];
    logic [31:0] q [$];

    imem_load_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .cpu_addr  (cpu_addr),
        .cpu_instr (cpu_instr),
        .cpu_stall (cpu_stall),
        .ld_count  (ld_count),
        .ld_err    (ld_err),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h exp %h", tag, got, exp);
    endtask

    // Called at a negedge; leaves the DUT in LOAD at the next negedge
    task automatic start();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        wp = 0;
    endtask

    task automatic send(input logic [31:0] d, input bit last);
        int t = 0;
        bit wr = 1'b1;
        ld_data  = d;
        ld_last  = last;
        ld_valid = 1'b1;
        while (ld_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready", {31'd0, ld_ready}, 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        wr = !last;
`endif
        if (wr) begin
            m[wp] = d;
            wp++;
        end
    endtask

    task automatic fetch(input int lo, input int n);
        logic [31:0] ad;
        for (int a = lo; a < lo + n; a++) begin
            q.push_back(m[a]);
            ad = $urandom;
            ad[7:2] = a[5:0];
            cpu_addr = ad;
            #1;
            chk($sformatf("fetch%0d", a), cpu_instr, q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_count", {25'd0, ld_count}, 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_err", {31'd0, ld_err}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd1);
        chk("rst_instr", cpu_instr, NOP);
        @(negedge clk);
        reset = 1'b1;

        ld_valid = 1'b1;
        repeat (2) @(negedge clk);
        ld_valid = 1'b0;
        chk("idle_stall", {31'd0, cpu_stall}, 32'd1);
        chk("idle_count", {25'd0, ld_count}, 32'd0);

`ifdef IMEM_CHECKSUM_EN
        start();
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h3, 1'b1);
        chk("ck_count", {25'd0, ld_count}, 32'd2);
        chk("ck_stall", {31'd0, cpu_stall}, 32'd1);
        chk("ck_wait", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("ck_done", {31'd0, done}, 32'd1);
        fetch(0, 2);

        start();
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h4, 1'b1);
        chk("bad_wait", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("bad_err", {31'd0, ld_err}, 32'd1);
        chk("bad_done", {31'd0, done}, 32'd0);

        start();
        chk("clr_err", {31'd0, ld_err}, 32'd0);
        send(32'h0, 1'b1);
        @(negedge clk);
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_cnt", {25'd0, ld_count}, 32'd0);
`else
        start();
        send(32'h0080_0093, 1'b0);
        send(32'h0040_0113, 1'b0);
        send(32'h0010_d093, 1'b1);
        chk("l3_count", {25'd0, ld_count}, 32'd3);
        chk("l3_done", {31'd0, done}, 32'd1);
        chk("l3_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_addr = 32'd8;
        #1;
        chk("addr8", cpu_instr, 32'h0010_d093);
        fetch(0, 3);

        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        wp = 0;
        chk("rl_stall", {31'd0, cpu_stall}, 32'd1);
        chk("rl_instr", cpu_instr, NOP);
        chk("rl_count", {25'd0, ld_count}, 32'd0);

        send(32'h0000_00AA, 1'b0);
        send(32'h0000_00BB, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 32'h0000_00CC;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        wp = 0;
        chk("restart_cnt", {25'd0, ld_count}, 32'd0);

        for (int i = 0; i < 64; i++) begin
            ld_data = 32'hA000_0000 | i;
            m[i] = ld_data;
            @(negedge clk);
        end
        chk("ov_ready", {31'd0, ld_ready}, 32'd0);
        chk("ov_count", {25'd0, ld_count}, 32'd64);
        chk("ov_noerr", {31'd0, ld_err}, 32'd0);
        @(negedge clk);
        chk("ov_err", {31'd0, ld_err}, 32'd1);
        chk("ov_stall", {31'd0, cpu_stall}, 32'd1);
        chk("ov_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        ld_valid = 1'b0;
        chk("er_hold", {31'd0, ld_err}, 32'd1);
        chk("er_count", {25'd0, ld_count}, 32'd64);

        start();
        chk("rc_count", {25'd0, ld_count}, 32'd0);
        chk("rc_err", {31'd0, ld_err}, 32'd0);
        send(32'h1234_5678, 1'b1);
        chk("rc_done", {31'd0, done}, 32'd1);
        fetch(0, 64);

        start();
        for (int i = 0; i < 5; i++) send(32'hB000_0000 | i, 1'b0);
        chk("ab_count", {25'd0, ld_count}, 32'd5);
        #3;
        reset = 1'b0;
        #1;
        chk("ab_count0", {25'd0, ld_count}, 32'd0);
        chk("ab_ready", {31'd0, ld_ready}, 32'd0);
        chk("ab_stall", {31'd0, cpu_stall}, 32'd1);
        chk("ab_instr", cpu_instr, NOP);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start();
        send(32'hC0FF_EE13, 1'b1);
        chk("nl_count", {25'd0, ld_count}, 32'd1);
        fetch(0, 8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 ld_start  input  1  one-cycle pulse; begins or restarts a program load.
REQ-004 ld_valid  input  1  loader word valid.
REQ-005 ld_ready  output  1  controller accepts a word this cycle.
REQ-006 ld_data  input  32  instruction word, or the checksum word when IMEM_CHECKSUM_EN is defined.
REQ-007 ld_last  input  1  qualifies the final word of the load, sampled with ld_valid.
REQ-008 cpu_addr  input  32  byte fetch address from the core PC.
REQ-009 cpu_instr  output  32  fetched instruction.
REQ-010 cpu_stall  output  1  core shall hold its PC while high.
REQ-011 ld_count  output  7  number of instruction words written in the current load, 0..64.
REQ-012 ld_err  output  1  load failed: overflow, or checksum mismatch.
REQ-013 done  output  1  program loaded; core running.

Function
REQ-014 Storage shall be 64 x 32-bit words, written only by this block and never cleared by reset.
REQ-015 States: IDLE, LOAD, CHECK, RUN, ERROR.
REQ-016 IDLE->LOAD, RUN->LOAD and ERROR->LOAD shall occur on ld_start, clearing ld_count, ld_err and the checksum accumulator.
REQ-017 In LOAD, ld_start shall restart the load: count 0, and any word presented that cycle is discarded.
REQ-018 ld_ready shall be 1 only in LOAD with ld_count<64.
REQ-019 A handshake (ld_valid & ld_ready) shall write ld_data to word ld_count, then increment ld_count, in the same edge.
REQ-020 In LOAD with ld_count==64 and ld_valid=1, the next state shall be ERROR.
REQ-021 An accepted word with ld_last=1 ends the load: next state CHECK if IMEM_CHECKSUM_EN is defined, else RUN.
REQ-022 In ERROR, ld_err shall be 1 until ld_start or reset.
REQ-023 In RUN: cpu_stall=0, done=1, and cpu_instr=mem[cpu_addr[7:2]] combinationally (zero-cycle latency; cpu_addr[1:0] and [31:8] ignored).
REQ-024 Outside RUN: cpu_stall=1, done=0, cpu_instr=32'h00000013 (nop).
REQ-025 ld_valid outside LOAD shall be ignored; no write, no state change.
REQ-026 ld_count shall saturate at 64 and never wrap.

Reset
REQ-027 While reset=0, asynchronously: state IDLE, ld_count 0, ld_err 0, done 0, cpu_stall 1, ld_ready 0, cpu_instr nop, checksum 0.
REQ-028 Reset asserted mid-load shall abandon the load; memory keeps any words already written.

Configuration
REQ-029 Macro IMEM_CHECKSUM_EN.
REQ-030 Defined: the ld_last word is a checksum and is not written or counted. CHECK lasts one cycle and compares the 32-bit wraparound sum of the written words with that word: match->RUN, mismatch->ERROR.
REQ-031 Defined: a load consisting only of the checksum word shall compare against a sum of 0.
REQ-032 Undefined: no CHECK state and no accumulator; the ld_last word is a normal instruction, written and counted.

Verification
REQ-033 Reset, then ld_start and 3 words 0x00800093, 0x00400113, 0x0010d093 (last on the third; macro undefined) -> ld_count=3, done=1 one cycle later; cpu_addr=8 -> cpu_instr=0x0010d093.
REQ-034 ld_valid held high through 65 words with no ld_last -> ld_ready=0 at count 64, ERROR, ld_err=1, cpu_stall=1.
REQ-035 Macro defined: words 0x1, 0x2, then checksum 0x3 with last -> CHECK one cycle, then RUN. Repeat with checksum 0x4 -> ERROR.
REQ-036 ld_start while in RUN -> cpu_stall=1, cpu_instr=0x00000013, ld_count=0 on the next cycle.
REQ-037 reset=0 asserted asynchronously mid-load after 5 words -> immediate IDLE and ld_count=0. A new load of 1 word then leaves words 1..4 unchanged, verified by fetch.
